// File: rtl/attenuation_ramp.sv
// attenuation_ramp: per-channel attenuation targets loaded from a serial
// frame carried on a qualified control byte, with every channel's current
// value ramping one LSB per divider period toward its target. A separate
// control byte sets the registered mute flag.
module attenuation_ramp #(
  parameter int NUM_CH   = 2,
  parameter int ATT_W    = 6,
  parameter int CMD_W    = 2,
  parameter int RAMP_DIV = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    data_valid,
  input  logic [7:0]              data,
  output logic                    is_muted,
  output logic [NUM_CH*ATT_W-1:0] ch_db,
  output logic                    db_val_valid,
  output logic                    ramp_busy,
  output logic                    frame_err
);

  localparam int FRAME_LEN = 3 + CMD_W + ATT_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int DIV_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } dec_state_e;

  // ---------------------------------------------------------------------
  // Byte classification
  // ---------------------------------------------------------------------
  logic is_muted_q, is_muted_d;
  logic prev_sclk_q, prev_sclk_d;

  logic ctl_byte;    // mute-control byte (data[4]=1)
  logic frame_byte;  // byte that feeds the serial decoder
  logic bit_evt;     // rising SCLK seen across successive frame bytes
  logic commit_evt;  // LATCH with SCLK low

  assign ctl_byte   = data_valid & data[4];
  assign frame_byte = data_valid & ~data[4];
  assign bit_evt    = frame_byte & data[2] & ~prev_sclk_q;
  assign commit_evt = frame_byte & data[0] & ~data[2];

  // Mute flag follows data[0] of control bytes; SCLK history only tracks
  // frame bytes so a mute byte can never fake or hide an edge.
  always_comb begin
    is_muted_d  = is_muted_q;
    prev_sclk_d = prev_sclk_q;
    if (ctl_byte) begin
      is_muted_d = data[0];
    end
    if (frame_byte) begin
      prev_sclk_d = data[2];
    end
  end

  // Mute and SCLK history registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_muted_q  <= 1'b0;
      prev_sclk_q <= 1'b0;
    end else begin
      is_muted_q  <= is_muted_d;
      prev_sclk_q <= prev_sclk_d;
    end
  end

  // ---------------------------------------------------------------------
  // Serial frame decoder
  // ---------------------------------------------------------------------
  dec_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [FRAME_LEN-1:0] shifted;
  logic [CMD_W-1:0]     cmd_fld;
  logic [ATT_W-1:0]     att_fld;
  logic                 cmd_ok;
  logic                 commit_full;
  logic                 err_d;

  // Shift register holds header, cmd and attenuation MSB first; once full
  // the payload occupies the low CMD_W+ATT_W bits.
  assign shifted = {shreg_q[FRAME_LEN-2:0], data[1]};
  assign cmd_fld = shreg_q[ATT_W +: CMD_W];
  assign att_fld = shreg_q[ATT_W-1:0];
  assign cmd_ok  = (cmd_fld == {CMD_W{1'b1}}) ||
                   ((cmd_fld != '0) && (cmd_fld <= CMD_W'(NUM_CH)));

  // Decoder next state: counts bits, checks the header after three bits,
  // and turns overflow, early commit or bad cmd into a frame error.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    err_d       = 1'b0;
    commit_full = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_evt) begin
          shreg_d = {{(FRAME_LEN-1){1'b0}}, data[1]};
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_evt) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + 1'b1;
          if ((cnt_q == CNT_W'(2)) && (shifted[2:0] != 3'b111)) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            state_d = FULL;
          end
        end else if (commit_evt) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      FULL: begin
        if (bit_evt) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (commit_evt) begin
          commit_full = 1'b1;
          err_d       = ~cmd_ok;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Decoder state registers; a reset discards any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // ---------------------------------------------------------------------
  // Ramp divider shared by all channels
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  assign tick = (div_q == DIV_W'(RAMP_DIV - 1));

  // Free-running 0..RAMP_DIV-1 counter; tick marks the ramp step.
  always_comb begin
    div_d = div_q + 1'b1;
    if (tick) begin
      div_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel target and current value
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] busy_vec;
  logic [NUM_CH-1:0] chg_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ATT_W-1:0] tgt_q, tgt_d;
      logic [ATT_W-1:0] cur_q, cur_d;
      logic             load;

      assign load = commit_full &&
                    ((cmd_fld == {CMD_W{1'b1}}) || (cmd_fld == CMD_W'(gi + 1)));

      // Target loads on commit; current steps one LSB toward the target
      // seen before this edge, so a new target redirects the ramp from
      // wherever it currently is.
      always_comb begin
        tgt_d = tgt_q;
        cur_d = cur_q;
        if (load) begin
          tgt_d = att_fld;
        end
        if (tick) begin
          if (cur_q < tgt_q) begin
            cur_d = cur_q + 1'b1;
          end else if (cur_q > tgt_q) begin
            cur_d = cur_q - 1'b1;
          end
        end
      end

      // Channel target/current registers.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          tgt_q <= '0;
          cur_q <= '0;
        end else begin
          tgt_q <= tgt_d;
          cur_q <= cur_d;
        end
      end

      assign busy_vec[gi]                = (cur_q != tgt_q);
      assign chg_vec[gi]                 = tick && (cur_q != tgt_q);
      assign ch_db[gi*ATT_W +: ATT_W]    = cur_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Status pulses
  // ---------------------------------------------------------------------
  logic db_val_valid_q, db_val_valid_d;
  logic frame_err_q;

  assign db_val_valid_d = |chg_vec;

  // Change and error pulses are registered so they line up with the
  // ch_db value / decoder state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_val_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      db_val_valid_q <= db_val_valid_d;
      frame_err_q    <= err_d;
    end
  end

  assign is_muted     = is_muted_q;
  assign db_val_valid = db_val_valid_q;
  assign frame_err    = frame_err_q;
  assign ramp_busy    = |busy_vec;

  // Byte bits with no function, and the header MSB which never leaves the
  // top of the shift register.
  logic unused_bits;
  assign unused_bits = ^{data[7:5], data[3], shreg_q[FRAME_LEN-1]};

endmodule

// File: tb/tb_attenuation_ramp.sv
// Self-checking bench for attenuation_ramp: directed scenarios followed by
// random traffic, compared every cycle against a queue-based model.
module tb_attenuation_ramp;

  localparam int NUM_CH    = 2;
  localparam int ATT_W     = 6;
  localparam int CMD_W     = 2;
  localparam int RAMP_DIV  = 4;
  localparam int FRAME_LEN = 3 + CMD_W + ATT_W;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    data_valid = 1'b0;
  logic [7:0]              data = 8'h00;
  logic                    is_muted;
  logic [NUM_CH*ATT_W-1:0] ch_db;
  logic                    db_val_valid;
  logic                    ramp_busy;
  logic                    frame_err;

  always #5 clk = ~clk;

  attenuation_ramp #(
    .NUM_CH  (NUM_CH),
    .ATT_W   (ATT_W),
    .CMD_W   (CMD_W),
    .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_valid  (data_valid),
    .data        (data),
    .is_muted    (is_muted),
    .ch_db       (ch_db),
    .db_val_valid(db_val_valid),
    .ramp_busy   (ramp_busy),
    .frame_err   (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dbv_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cur[NUM_CH];
  int m_tgt[NUM_CH];
  int m_muted, m_div, m_prev;
  int m_bits[$];
  bit m_dbv, m_err;
  bit m_in_reset = 1'b1;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cur[c] = 0;
      m_tgt[c] = 0;
    end
    m_muted = 0;
    m_div   = 0;
    m_prev  = 0;
    m_dbv   = 0;
    m_err   = 0;
    m_bits.delete();
  endfunction

  function automatic void model_edge(input bit v, input logic [7:0] d);
    bit tick;
    int cmd, att;
    m_dbv = 0;
    m_err = 0;
    tick  = (m_div == RAMP_DIV - 1);
    m_div = tick ? 0 : m_div + 1;
    // Ramp uses the targets as they stood before this edge.
    for (int c = 0; c < NUM_CH; c++) begin
      if (tick && m_cur[c] != m_tgt[c]) begin
        m_cur[c] += (m_cur[c] < m_tgt[c]) ? 1 : -1;
        m_dbv = 1;
      end
    end
    if (!v) return;
    if (d[4]) begin
      m_muted = d[0];
      return;
    end
    if (d[2] && m_prev == 0) begin
      if (m_bits.size() == FRAME_LEN) begin
        m_err = 1;
        m_bits.delete();
      end else begin
        m_bits.push_back(int'(d[1]));
        if (m_bits.size() == 3 && !(m_bits[0] == 1 && m_bits[1] == 1 && m_bits[2] == 1)) begin
          m_err = 1;
          m_bits.delete();
        end
      end
    end else if (d[0] && !d[2]) begin
      if (m_bits.size() == FRAME_LEN) begin
        cmd = 0;
        att = 0;
        for (int k = 0; k < CMD_W; k++) cmd = cmd * 2 + m_bits[3 + k];
        for (int k = 0; k < ATT_W; k++) att = att * 2 + m_bits[3 + CMD_W + k];
        if (cmd == (1 << CMD_W) - 1) begin
          for (int c = 0; c < NUM_CH; c++) m_tgt[c] = att;
        end else if (cmd >= 1 && cmd <= NUM_CH) begin
          m_tgt[cmd - 1] = att;
        end else begin
          m_err = 1;
        end
        m_bits.delete();
      end else if (m_bits.size() > 0) begin
        m_err = 1;
        m_bits.delete();
      end
    end
    m_prev = int'(d[2]);
  endfunction

  task automatic check_outputs();
    int e_db;
    int e_busy;
    e_db   = 0;
    e_busy = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      e_db = e_db | (m_cur[c] << (c * ATT_W));
      if (m_cur[c] != m_tgt[c]) e_busy = 1;
    end
    check("ch_db", 32'(ch_db), e_db);
    check("is_muted", 32'(is_muted), m_muted);
    check("ramp_busy", 32'(ramp_busy), e_busy);
    check("db_val_valid", 32'(db_val_valid), 32'(m_dbv));
    check("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input logic [7:0] d);
    data_valid = v;
    data       = d;
    @(posedge clk);
    if (!m_in_reset) model_edge(v, d);
    #1;
    check_outputs();
    if (db_val_valid) dbv_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send_bit(input bit b);
    logic [7:0] d;
    d    = 8'h00;
    d[1] = b;
    step(1'b1, d);
    d[2] = 1'b1;
    step(1'b1, d);
  endtask

  task automatic send_bits(input int value, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bit'((value >> i) & 1));
  endtask

  task automatic send_frame(input int cmd, input int att);
    send_bits(7, 3);
    send_bits(cmd, CMD_W);
    send_bits(att, ATT_W);
  endtask

  task automatic commit();
    step(1'b1, 8'h01);
  endtask

  // Step idle cycles until the model's ch0 reaches lim (from below if up).
  task automatic wait_ch0(input string tag, input int lim, input int budget);
    int n;
    n = 0;
    while (m_cur[0] != lim && n < budget) begin
      idle(1);
      n++;
    end
    if (m_cur[0] != lim) check(tag, 32'(ch_db[ATT_W-1:0]), lim);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    #3;
    check_outputs();
    check("rst_ch_db", 32'(ch_db), 0);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    m_in_reset = 1'b0;

    // Mute control leaves ch_db alone.
    step(1'b1, 8'h17);
    check("mute_on", 32'(is_muted), 1);
    step(1'b1, 8'h10);
    check("mute_off", 32'(is_muted), 0);
    step(1'b0, 8'h17);
    check("mute_ignored_invalid", 32'(is_muted), 0);

    // Single channel ramp 0 -> 41.
    send_frame(1, 41);
    dbv_seen = 0;
    commit();
    idle(170);
    check("single_ch0", 32'(ch_db[ATT_W-1:0]), 41);
    check("single_ch1", 32'(ch_db[2*ATT_W-1:ATT_W]), 0);
    check("single_pulses", dbv_seen, 41);
    check("single_busy", 32'(ramp_busy), 0);

    // Reset mid-ramp, with mute set and a partial frame pending.
    send_frame(1, 0);
    commit();
    idle(170);
    step(1'b1, 8'h11);
    send_frame(1, 41);
    commit();
    send_bits(7, 3);
    wait_ch0("wait_ch0_20", 20, 200);
    #2;
    reset_n    = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid_ch_db", 32'(ch_db), 0);
    check("rst_mid_busy", 32'(ramp_busy), 0);
    check("rst_mid_muted", 32'(is_muted), 0);
    idle(3);
    reset_n    = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    m_in_reset = 1'b0;

    // Broadcast to 11, then redirect ch0 to 5 mid-ramp.
    send_frame(3, 11);
    commit();
    send_frame(1, 5);
    wait_ch0("wait_ch0_6", 6, 100);
    commit();
    idle(80);
    check("bc_ch0", 32'(ch_db[ATT_W-1:0]), 5);
    check("bc_ch1", 32'(ch_db[2*ATT_W-1:ATT_W]), 11);

    // Bad header 1,1,0.
    send_bits(6, 3);
    check("err_header", 32'(frame_err), 1);
    commit();
    // Commit after 8 bits.
    send_bits(7, 3);
    send_bits(1, 2);
    send_bits(5, 3);
    commit();
    check("err_short_commit", 32'(frame_err), 1);
    // cmd 00.
    send_frame(0, 20);
    commit();
    check("err_cmd00", 32'(frame_err), 1);
    // 12th bit overflows.
    send_frame(2, 20);
    send_bit(1'b1);
    check("err_overflow", 32'(frame_err), 1);
    commit();
    idle(10);
    check("err_no_change", 32'(ch_db), 5 | (11 << ATT_W));
    // Commit equal to current value: no pulse.
    send_frame(1, 5);
    dbv_seen = 0;
    commit();
    idle(10);
    check("same_no_pulse", dbv_seen, 0);

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        step(bit'($urandom_range(0, 1)), 8'($urandom));
      end else if (r <= 8) begin
        send_frame($urandom_range(0, 3), $urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) commit();
      end else begin
        idle($urandom_range(0, 12));
      end
    end
    idle(300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
